// File: rtl/shift_exec_stage.sv
// Two-stage pipelined RV32 execute-stage shift unit.
// S1 registers the operands and computes the shift; S2 holds the result for writeback.
// Every shift uses two left-shifter instances: right shifts go through bit reversal,
// and the arithmetic sign fill is a reversed, inverted left-shifted all-ones mask.

// Logarithmic left shifter shared by all shift operations.
module sll #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]         data_i,
    input  logic [$clog2(N)-1:0] sh_i,
    output logic [N-1:0]         data_o
);

    localparam int unsigned ShW = $clog2(N);

    // One conditional power-of-two shift per bit of the shift amount.
    always_comb begin
        data_o = data_i;
        for (int i = 0; i < int'(ShW); i++) begin
            if (sh_i[i]) begin
                data_o = data_o << (1 << i);
            end
        end
    end

endmodule

module shift_exec_stage #(
    parameter int unsigned N    = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [TAGW-1:0] out_tag,
    output logic            out_illegal,
    output logic [15:0]     op_count
);

    localparam int unsigned ShW = $clog2(N);

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b11;

    function automatic logic [N-1:0] rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < int'(N); i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    // Stage 1: operand register
    logic            s1_valid_q, s1_valid_d;
    logic [1:0]      s1_op_q, s1_op_d;
    logic [N-1:0]    s1_a_q, s1_a_d;
    logic [ShW-1:0]  s1_sh_q, s1_sh_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;

    // Stage 2: result register
    logic            s2_valid_q, s2_valid_d;
    logic [N-1:0]    s2_result_q, s2_result_d;
    logic [TAGW-1:0] s2_tag_q, s2_tag_d;
    logic            s2_illegal_q, s2_illegal_d;

    logic [15:0]     op_count_q, op_count_d;

    logic adv2;
    logic in_xfer;
    logic out_xfer;

    // Only the low shift-amount bits matter; the rest of in_b is intentionally dropped.
    logic unused_b_hi;
    assign unused_b_hi = ^in_b[N-1:ShW];

    assign adv2     = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv2;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid_q && out_ready;

    // Shift datapath, all from S1 registers.
    logic [N-1:0] a_rev;
    logic [N-1:0] sh_src;
    logic [N-1:0] sh_out;
    logic [N-1:0] mask_out;
    logic [N-1:0] srl_res;
    logic [N-1:0] sign_fill;
    logic [N-1:0] s1_result;
    logic         s1_illegal;

    assign a_rev  = rev(s1_a_q);
    assign sh_src = (s1_op_q == OpSll) ? s1_a_q : a_rev;

    sll #(
        .N (N)
    ) u_sll_data (
        .data_i (sh_src),
        .sh_i   (s1_sh_q),
        .data_o (sh_out)
    );

    // All-ones shifted left, reversed and inverted, marks the vacated high bits.
    sll #(
        .N (N)
    ) u_sll_mask (
        .data_i ({N{1'b1}}),
        .sh_i   (s1_sh_q),
        .data_o (mask_out)
    );

    assign srl_res   = rev(sh_out);
    assign sign_fill = s1_a_q[N-1] ? ~rev(mask_out) : '0;

    // Select the result for the decoded operation; reserved encoding yields zero.
    always_comb begin
        s1_result  = '0;
        s1_illegal = 1'b0;
        unique case (s1_op_q)
            OpSll:   s1_result = sh_out;
            OpSrl:   s1_result = srl_res;
            OpSra:   s1_result = srl_res | sign_fill;
            default: s1_illegal = 1'b1;
        endcase
    end

    // Pipeline next-state; flush overrides every other update.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_op_d      = s1_op_q;
        s1_a_d       = s1_a_q;
        s1_sh_d      = s1_sh_q;
        s1_tag_d     = s1_tag_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_tag_d     = s2_tag_q;
        s2_illegal_d = s2_illegal_q;
        op_count_d   = op_count_q;

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (out_xfer) begin
                op_count_d = op_count_q + 16'd1;
            end
            if (adv2) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_d  = s1_result;
                    s2_tag_d     = s1_tag_q;
                    s2_illegal_d = s1_illegal;
                end
                s1_valid_d = 1'b0;
            end
            if (in_xfer) begin
                s1_valid_d = 1'b1;
                s1_op_d    = in_op;
                s1_a_d     = in_a;
                s1_sh_d    = in_b[ShW-1:0];
                s1_tag_d   = in_tag;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= 2'b00;
            s1_a_q       <= '0;
            s1_sh_q      <= '0;
            s1_tag_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_tag_q     <= '0;
            s2_illegal_q <= 1'b0;
            op_count_q   <= 16'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_a_q       <= s1_a_d;
            s1_sh_q      <= s1_sh_d;
            s1_tag_q     <= s1_tag_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_tag_q     <= s2_tag_d;
            s2_illegal_q <= s2_illegal_d;
            op_count_q   <= op_count_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_tag     = s2_tag_q;
    assign out_illegal = s2_illegal_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: accepted ops push their expected result,
// a separate monitor pops and compares on each retired output.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic [15:0] op_count;

    shift_exec_stage #(
        .N    (32),
        .TAGW (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] drv_res;
    logic        drv_ill;
    logic [15:0] cnt_model;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b11:   return $unsigned($signed(a) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    // Inputs are stable from posedge+1 to the next posedge, so negedge sees the handshake.
    always @(negedge clk) begin
        if (rst || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back('{res: drv_res, tag: in_tag, ill: drv_ill});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            cnt_model <= 16'd0;
        end else if (!flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got tag %h result %h, expected none",
                         out_tag, out_result);
            end else begin
                e = exp_q.pop_front();
                check("out_result", out_result, e.res);
                check("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
                check("out_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            end
            cnt_model <= cnt_model + 16'd1;
        end
    end

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] er, input logic ei);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        drv_res  = er;
        drv_ill  = ei;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(output int waits);
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 100);
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL accept_timeout: in_ready %b after %0d cycles, expected 1",
                     in_ready, waits);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] er, input logic ei);
        int w;
        drive(op, a, b, tag, er, ei);
        wait_accept(w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic acc;
        logic [1:0] rop;
        logic [31:0] ra, rb;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0; drv_res = '0; drv_ill = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(2);
        rst = 1'b0;

        // Basic latency and shift vectors
        send(2'b00, 32'h0000_0001, 32'd31, 5'd3, 32'h8000_0000, 1'b0);
        check("lat_s1_only", {31'd0, out_valid}, 32'd0);
        idle(1);
        check("lat_out_valid", {31'd0, out_valid}, 32'd1);
        check("lat_out_result", out_result, 32'h8000_0000);
        send(2'b11, 32'h8000_0000, 32'h0000_0024, 5'd4, 32'hF800_0000, 1'b0);
        send(2'b01, 32'h8000_0000, 32'h0000_0024, 5'd5, 32'h0800_0000, 1'b0);
        send(2'b11, 32'h8000_0001, 32'd31, 5'd6, 32'hFFFF_FFFF, 1'b0);
        send(2'b11, 32'h7000_0000, 32'd4, 5'd7, 32'h0700_0000, 1'b0);
        send(2'b01, 32'hFFFF_FFFF, 32'h0000_0020, 5'd8, 32'hFFFF_FFFF, 1'b0);
        send(2'b00, 32'h1234_5678, 32'd4, 5'd9, 32'h2345_6780, 1'b0);
        send(2'b11, 32'h8000_0000, 32'd0, 5'd10, 32'h8000_0000, 1'b0);
        idle(4);

        // Stream of 8 from a clean count
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("count_after_rst", {16'd0, op_count}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 32'h1, i, 5'(i + 16), 32'h1 << i, 1'b0);
            wait_accept(w);
            check("stream_one_per_cycle", w, 32'd1);
        end
        idle(4);
        check("stream_op_count", {16'd0, op_count}, 32'd8);

        // Backpressure: two accepted, third stalls
        out_ready = 1'b0;
        send(2'b00, 32'h3, 32'd1, 5'd1, 32'h6, 1'b0);
        send(2'b01, 32'h80, 32'd3, 5'd2, 32'h10, 1'b0);
        drive(2'b11, 32'hF000_0000, 32'd8, 5'd3, 32'hFFF0_0000, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_result", out_result, 32'h6);
            check("stall_out_tag", {27'd0, out_tag}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept(w);
        idle(4);
        check("stall_op_count", {16'd0, op_count}, 32'd11);

        // Flush with both stages full, coincident with out/in handshakes
        out_ready = 1'b0;
        send(2'b00, 32'h1, 32'd1, 5'd11, 32'h2, 1'b0);
        send(2'b00, 32'h1, 32'd2, 5'd12, 32'h4, 1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(2'b00, 32'h1, 32'd3, 5'd13, 32'h8, 1'b0);
        idle(1);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush_op_count", {16'd0, op_count}, 32'd11);
        check("flush_stale_result", out_result, 32'h2);
        idle(2);
        check("flush_discard_in", {31'd0, out_valid}, 32'd0);
        send(2'b01, 32'hF0, 32'd4, 5'd14, 32'hF, 1'b0);
        idle(4);
        check("post_flush_count", {16'd0, op_count}, 32'd12);

        // Reserved op, then async reset mid-stream
        send(2'b10, 32'hFFFF_FFFF, 32'd3, 5'd15, 32'h0, 1'b1);
        idle(1);
        check("illegal_flag", {31'd0, out_illegal}, 32'd1);
        check("illegal_result", out_result, 32'd0);
        idle(3);
        out_ready = 1'b0;
        send(2'b00, 32'h5, 32'd2, 5'd20, 32'h14, 1'b0);
        send(2'b01, 32'h5, 32'd2, 5'd21, 32'h1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_result", out_result, 32'd0);
        check("arst_out_tag", {27'd0, out_tag}, 32'd0);
        check("arst_out_illegal", {31'd0, out_illegal}, 32'd0);
        check("arst_op_count", {16'd0, op_count}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        idle(1);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(1);

        // Random traffic against a reference shift model
        for (int c = 0; c < 1500; c++) begin
            flush = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid) begin
                rop = 2'($urandom_range(0, 3));
                ra = $urandom;
                rb = $urandom;
                drive(rop, ra, rb, 5'(c), ref_shift(rop, ra, rb), rop == 2'b10);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            acc = in_valid && in_ready && !flush;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        idle(5);
        check("drain_queue_empty", exp_q.size(), 32'd0);
        check("rand_op_count", {16'd0, op_count}, {16'd0, cnt_model});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
